// File: rtl/bsg_manycore_pkg.sv
// Shared manycore definitions: command/packet op encoding, packet header
// layout and the coordinate-width helper used by edge bridges and tiles.
package bsg_manycore_pkg;

    localparam int op_width_gp   = 2;
    localparam int mask_width_gp = 4;

    typedef enum logic [1:0] {
        e_op_store    = 2'b00,
        e_op_load     = 2'b01,
        e_op_fence    = 2'b10,
        e_op_reserved = 2'b11
    } bsg_manycore_op_e;

    // Fixed-width leading fields of every packet; coordinate, address and
    // data fields follow and are sized by the instantiating module.
    typedef struct packed {
        bsg_manycore_op_e            op;
        logic [mask_width_gp-1:0]    mask;
    } bsg_manycore_pkt_hdr_s;

    // clog2 that never returns zero, so a 1-wide array still gets a 1-bit field.
    function automatic int safe_clog2(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry valid/ready FIFO. Input ready is simply "not full", so with the
// consumer always ready it never fills and passes one item per cycle.
module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               ready_i
);

    logic [width_p-1:0] mem_reg [2];
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic [1:0]         count_reg;
    logic               enq;
    logic               deq;

    assign ready_o = (count_reg != 2'd2);
    assign v_o     = (count_reg != 2'd0);
    assign data_o  = mem_reg[rd_ptr_reg];
    assign enq     = v_i & ready_o;
    assign deq     = v_o & ready_i;

    // Pointer and occupancy tracking; reset empties the FIFO immediately.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (enq) wr_ptr_reg <= ~wr_ptr_reg;
            if (deq) rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, enq} - {1'b0, deq};
        end
    end

    // Storage needs no reset: contents are only visible while v_o is high.
    always_ff @(posedge clk_i) begin
        if (enq) mem_reg[wr_ptr_reg] <= data_i;
    end

endmodule

// File: rtl/bsg_manycore_edge_bridge.sv
// Host-side endpoint for one edge port of the manycore array. Host commands
// become outbound packets, inbound packets become host responses, loads are
// throttled by an outstanding counter and fences wait for traffic to drain.
module bsg_manycore_edge_bridge
    import bsg_manycore_pkg::*;
#(
    parameter int num_tiles_x_p   = 4,
    parameter int num_tiles_y_p   = 4,
    parameter int data_width_p    = 32,
    parameter int addr_width_p    = 32,
    parameter int max_out_p       = 8,
    parameter int x_cord_width_lp = safe_clog2(num_tiles_x_p),
    parameter int y_cord_width_lp = safe_clog2(num_tiles_y_p + 1),
    parameter int packet_width_lp = 6 + x_cord_width_lp + y_cord_width_lp + addr_width_p + data_width_p,
    parameter int count_width_lp  = safe_clog2(max_out_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       cmd_v_i,
    input  logic [1:0]                 cmd_op_i,
    input  logic [3:0]                 cmd_mask_i,
    input  logic [x_cord_width_lp-1:0] cmd_x_i,
    input  logic [y_cord_width_lp-1:0] cmd_y_i,
    input  logic [addr_width_p-1:0]    cmd_addr_i,
    input  logic [data_width_p-1:0]    cmd_data_i,
    output logic                       cmd_ready_o,
    output logic [packet_width_lp-1:0] link_data_o,
    output logic                       link_v_o,
    input  logic                       link_ready_i,
    input  logic [packet_width_lp-1:0] link_data_i,
    input  logic                       link_v_i,
    output logic                       link_ready_o,
    output logic                       resp_v_o,
    output logic [addr_width_p-1:0]    resp_addr_o,
    output logic [data_width_p-1:0]    resp_data_o,
    input  logic                       resp_ready_i,
    output logic [count_width_lp-1:0]  outstanding_o,
    output logic                       fence_done_o,
    output logic                       error_o
);

    typedef struct packed {
        bsg_manycore_pkt_hdr_s       hdr;
        logic [y_cord_width_lp-1:0]  y;
        logic [x_cord_width_lp-1:0]  x;
        logic [addr_width_p-1:0]     addr;
        logic [data_width_p-1:0]     data;
    } packet_s;

    typedef enum logic {e_idle, e_fence} state_e;

    localparam logic [count_width_lp-1:0] max_out_lp = count_width_lp'(max_out_p);

    state_e                      state_reg;
    logic                        fence_done_reg;
    logic                        error_reg;
    logic [count_width_lp-1:0]   count_reg;
    logic [count_width_lp-1:0]   count_next;
    logic                        stray_arrival;

    bsg_manycore_op_e            op;
    packet_s                     out_pkt;
    packet_s                     in_head;
    logic [packet_width_lp-1:0]  in_data;
    logic                        out_ready;
    logic                        in_ready;
    logic                        cmd_ready;
    logic                        cmd_acc;
    logic                        load_acc;
    logic                        in_acc;
    logic                        unused_in_fields;

    assign op       = bsg_manycore_op_e'(cmd_op_i);
    assign cmd_acc  = cmd_v_i & cmd_ready;
    assign load_acc = cmd_acc & (op == e_op_load);
    assign in_acc   = link_v_i & in_ready;

    // Command acceptance: stores need FIFO room, loads also need credit;
    // fence and reserved ops are always taken while idle.
    always_comb begin
        cmd_ready = 1'b0;
        if (state_reg == e_idle) begin
            case (op)
                e_op_store: cmd_ready = out_ready;
                e_op_load:  cmd_ready = out_ready && (count_reg < max_out_lp);
                default:    cmd_ready = 1'b1;
            endcase
        end
    end

    // Outbound packet assembled straight from the command fields.
    always_comb begin
        out_pkt.hdr.op   = op;
        out_pkt.hdr.mask = cmd_mask_i;
        out_pkt.y        = cmd_y_i;
        out_pkt.x        = cmd_x_i;
        out_pkt.addr     = cmd_addr_i;
        out_pkt.data     = cmd_data_i;
    end

    // Next outstanding count; an arrival with nothing in flight is clamped at 0.
    always_comb begin
        count_next    = count_reg;
        stray_arrival = in_acc && (count_reg == '0);
        case ({load_acc, in_acc})
            2'b10:   count_next = count_reg + count_width_lp'(1);
            2'b01:   if (count_reg != '0) count_next = count_reg - count_width_lp'(1);
            default: count_next = count_reg;
        endcase
    end

    // Outstanding-load counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) count_reg <= '0;
        else            count_reg <= count_next;
    end

    // Fence FSM; release looks at the counter's next value so the fence ends
    // on the edge right after the last response is taken.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg      <= e_idle;
            fence_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                e_idle: begin
                    fence_done_reg <= 1'b0;
                    if (cmd_acc && (op == e_op_fence)) state_reg <= e_fence;
                end
                e_fence: begin
                    if (!link_v_o && (count_next == '0)) begin
                        state_reg      <= e_idle;
                        fence_done_reg <= 1'b1;
                    end
                end
                default: state_reg <= e_idle;
            endcase
        end
    end

    // Sticky error: reserved op accepted or an unexpected inbound packet.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) error_reg <= 1'b0;
        else if ((cmd_acc && (op == e_op_reserved)) || stray_arrival) error_reg <= 1'b1;
    end

    bsg_two_fifo #(.width_p(packet_width_lp)) out_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (out_pkt),
        .v_i       (cmd_acc && ((op == e_op_store) || (op == e_op_load))),
        .ready_o   (out_ready),
        .data_o    (link_data_o),
        .v_o       (link_v_o),
        .ready_i   (link_ready_i)
    );

    bsg_two_fifo #(.width_p(packet_width_lp)) in_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (link_data_i),
        .v_i       (link_v_i),
        .ready_o   (in_ready),
        .data_o    (in_data),
        .v_o       (resp_v_o),
        .ready_i   (resp_ready_i)
    );

    assign in_head          = in_data;
    assign unused_in_fields = ^{in_head.hdr, in_head.y, in_head.x};

    assign cmd_ready_o   = cmd_ready;
    assign link_ready_o  = in_ready;
    assign resp_addr_o   = in_head.addr;
    assign resp_data_o   = in_head.data;
    assign outstanding_o = count_reg;
    assign fence_done_o  = fence_done_reg;
    assign error_o       = error_reg;

endmodule
